// File: rtl/mux2_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux2_rr_arbiter
//
// Purpose:
//   Round-robin arbiter and sequencer for a shared 2:1 byte mux datapath.
//   Two requesters (A and B) compete for one registered output channel. A
//   grant is burst-locked: the granted side keeps the channel until it sends
//   a beat flagged as last, or until it has sent MAX_BURST beats. When both
//   sides are waiting, the side that did not hold the channel most recently
//   wins. The block owns the mux select and the output register. Both the
//   input and output sides use valid/ready handshakes.
//
// Optional feature:
//   ARB_STATS_EN - when defined, adds the CNT_W parameter and the cnt_a/cnt_b
//   ports. These are saturating counters of the beats accepted from each
//   side. When undefined, the ports and counters do not exist.
//
// Parameters:
//   WIDTH      data width of each requester and of the output
//   MAX_BURST  maximum beats per grant before a forced release (>= 1)
//   CNT_W      width of the statistics counters (ARB_STATS_EN only)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   a_valid    requester A has a beat
//   a_data     requester A beat data
//   a_last     A beat is the last of its burst
//   a_ready    A beat is accepted this cycle when a_valid is also high
//   b_valid    requester B has a beat
//   b_data     requester B beat data
//   b_last     B beat is the last of its burst
//   b_ready    B beat is accepted this cycle when b_valid is also high
//   out_valid  output register holds a beat
//   out_data   output beat
//   out_src    source of out_data: 0 = A, 1 = B
//   out_ready  downstream accepts out_data
//   cnt_a      beats accepted from A (ARB_STATS_EN only)
//   cnt_b      beats accepted from B (ARB_STATS_EN only)
// ---------------------------------------------------------------------------
module mux2_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
`ifdef ARB_STATS_EN
    ,
    parameter int CNT_W     = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready
`ifdef ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
`endif
);

    // The beat counter only needs to reach MAX_BURST-1 before it is cleared.
    localparam int BEAT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);

    // These encodings match the out_src convention.
    localparam logic SIDE_A = 1'b0;
    localparam logic SIDE_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               rrLast_q, rrLast_d;
    logic [BEAT_W-1:0]  beatCnt_q, beatCnt_d;
    logic               outValid_q, outValid_d;
    logic [WIDTH-1:0]   outData_q, outData_d;
    logic               outSrc_q, outSrc_d;

    logic               canLoad;
    logic               acceptA;
    logic               acceptB;

    // The output register can take a new beat when it is empty, or when its
    // current beat leaves this same cycle. This is what lets bursts run at
    // full rate. It also freezes the whole sequencer while downstream stalls.
    always_comb begin
        canLoad = ~outValid_q | out_ready;
        a_ready = (state_q == GRANT_A) & canLoad;
        b_ready = (state_q == GRANT_B) & canLoad;
        acceptA = a_valid & a_ready;
        acceptB = b_valid & b_ready;
    end

    // Arbitration and burst tracking.
    // From IDLE, the grant takes effect on the next cycle. Inside a grant,
    // only accepted beats advance the burst. A granted side that drops valid
    // keeps the channel until it finishes the burst.
    // On release, the channel goes straight to the other side if that side is
    // waiting, so a handover costs no bubble.
    always_comb begin
        state_d   = state_q;
        rrLast_d  = rrLast_q;
        beatCnt_d = beatCnt_q;

        case (state_q)
            IDLE: begin
                if (a_valid && b_valid) begin
                    state_d = (rrLast_q == SIDE_B) ? GRANT_A : GRANT_B;
                end else if (a_valid) begin
                    state_d = GRANT_A;
                end else if (b_valid) begin
                    state_d = GRANT_B;
                end
            end

            GRANT_A: begin
                if (acceptA) begin
                    if (a_last || (beatCnt_q == LAST_BEAT)) begin
                        rrLast_d  = SIDE_A;
                        beatCnt_d = '0;
                        state_d   = b_valid ? GRANT_B : IDLE;
                    end else begin
                        beatCnt_d = beatCnt_q + 1'b1;
                    end
                end
            end

            GRANT_B: begin
                if (acceptB) begin
                    if (b_last || (beatCnt_q == LAST_BEAT)) begin
                        rrLast_d  = SIDE_B;
                        beatCnt_d = '0;
                        state_d   = a_valid ? GRANT_A : IDLE;
                    end else begin
                        beatCnt_d = beatCnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d   = IDLE;
                beatCnt_d = '0;
            end
        endcase
    end

    // Output register, which also acts as the registered mux.
    // The select (out_src) is captured together with the data. Data and
    // source hold their values while empty, so only out_valid tells the
    // downstream whether the contents are live.
    always_comb begin
        outValid_d = outValid_q;
        outData_d  = outData_q;
        outSrc_d   = outSrc_q;

        if (acceptA) begin
            outValid_d = 1'b1;
            outData_d  = a_data;
            outSrc_d   = SIDE_A;
        end else if (acceptB) begin
            outValid_d = 1'b1;
            outData_d  = b_data;
            outSrc_d   = SIDE_B;
        end else if (out_ready) begin
            outValid_d = 1'b0;
        end
    end

    // State register. rrLast resets to B so that A wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rrLast_q   <= SIDE_B;
            beatCnt_q  <= '0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outSrc_q   <= SIDE_A;
        end else begin
            state_q    <= state_d;
            rrLast_q   <= rrLast_d;
            beatCnt_q  <= beatCnt_d;
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
            outSrc_q   <= outSrc_d;
        end
    end

    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign out_src   = outSrc_q;

`ifdef ARB_STATS_EN
    logic [CNT_W-1:0] cntA_q, cntA_d;
    logic [CNT_W-1:0] cntB_q, cntB_d;

    // Per-side accepted-beat counters. They stop at all-ones instead of
    // wrapping, so a long run never reports a misleadingly small count.
    always_comb begin
        cntA_d = cntA_q;
        cntB_d = cntB_q;
        if (acceptA && (cntA_q != '1)) begin
            cntA_d = cntA_q + 1'b1;
        end
        if (acceptB && (cntB_q != '1)) begin
            cntB_d = cntB_q + 1'b1;
        end
    end

    // Counter registers. They clear together with the rest of the block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cntA_q <= '0;
            cntB_q <= '0;
        end else begin
            cntA_q <= cntA_d;
            cntB_q <= cntB_d;
        end
    end

    assign cnt_a = cntA_q;
    assign cnt_b = cntB_q;
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux2_rr_arbiter
//
// Purpose:
//   Directed testbench for mux2_rr_arbiter (WIDTH=8, MAX_BURST=4).
//   Each test pushes its hand-computed output beats (data and source) into
//   an expectation queue. A separate monitor pops that queue and compares
//   whenever a beat leaves the output register. Inline checks cover the
//   reset values, stall and hold behaviour, and the zero-bubble streaming
//   cases. When ARB_STATS_EN is defined, the statistics counters are checked
//   as well, with CNT_W=4.
// ---------------------------------------------------------------------------
module tb_mux2_rr_arbiter;

    logic       clk;
    logic       rst;
    logic       a_valid;
    logic [7:0] a_data;
    logic       a_last;
    logic       a_ready;
    logic       b_valid;
    logic [7:0] b_data;
    logic       b_last;
    logic       b_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_src;
    logic       out_ready;
`ifdef ARB_STATS_EN
    logic [3:0] cnt_a;
    logic [3:0] cnt_b;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic       src;
    } exp_t;

    exp_t expQ[$];
    exp_t monEntry;
    int   checks = 0;
    int   passes = 0;

    mux2_rr_arbiter #(
        .WIDTH     (8),
        .MAX_BURST (4)
`ifdef ARB_STATS_EN
        ,
        .CNT_W     (4)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_last    (a_last),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_last    (b_last),
        .b_ready   (b_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
`ifdef ARB_STATS_EN
        ,
        .cnt_a     (cnt_a),
        .cnt_b     (cnt_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end else begin
            passes++;
        end
    endtask

    task automatic pushExp(input logic [7:0] d, input logic s);
        exp_t e;
        e.data = d;
        e.src  = s;
        expQ.push_back(e);
    endtask

    // Presents one beat on side 0 (A) or side 1 (B) and returns at posedge+1
    // after the handshake. Valid is left high so the next beat can follow
    // back to back.
    task automatic applyStimulus(input bit side, input logic [7:0] data, input bit last);
        int  waitCycles;
        bit  accepted;
        waitCycles = 0;
        accepted   = 1'b0;
        if (!side) begin
            a_valid = 1'b1; a_data = data; a_last = last;
        end else begin
            b_valid = 1'b1; b_data = data; b_last = last;
        end
        while (!accepted && waitCycles < 100) begin
            @(negedge clk);
            accepted = side ? b_ready : a_ready;
            waitCycles++;
        end
        if (!accepted) begin
            checks++;
            $display("[TB] FAIL handshake_timeout: side %0d data 0x%0h not accepted, required accept within 100 cycles",
                     side, data);
        end
        @(posedge clk);
        #1;
    endtask

    // Waits for the first live output, then requires out_valid on n
    // consecutive cycles (no bubbles).
    task automatic expectStreak(input string name, input int n);
        int waitCycles;
        waitCycles = 0;
        @(negedge clk);
        while (!out_valid && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput({name, "_start"}, {31'd0, out_valid}, 32'd1);
        for (int i = 1; i < n; i++) begin
            @(negedge clk);
            checkOutput({name, "_streak"}, {31'd0, out_valid}, 32'd1);
        end
    endtask

    task automatic waitDrain(input string name);
        int waitCycles;
        waitCycles = 0;
        while (expQ.size() != 0 && waitCycles < 100) begin
            @(negedge clk);
            #1;
            waitCycles++;
        end
        checkOutput({name, "_drained"}, expQ.size(), 32'd0);
    endtask

    task automatic resetDut();
        @(posedge clk);
        #1;
        rst = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0; a_last = 1'b0; b_last = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Scoreboard monitor: a beat leaves the output register at the next
    // posedge whenever out_valid and out_ready are both high here.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_beat: got data 0x%0h src %0d, required no beat",
                         out_data, out_src);
            end else begin
                monEntry = expQ.pop_front();
                checkOutput("out_data", {24'd0, out_data}, {24'd0, monEntry.data});
                checkOutput("out_src", {31'd0, out_src}, {31'd0, monEntry.src});
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        a_valid = 1'b0; a_data = 8'h00; a_last = 1'b0;
        b_valid = 1'b0; b_data = 8'h00; b_last = 1'b0;
        out_ready = 1'b0;

        // Reset values.
        #1;
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_out_data", {24'd0, out_data}, 32'd0);
        checkOutput("rst_out_src", {31'd0, out_src}, 32'd0);
        checkOutput("rst_a_ready", {31'd0, a_ready}, 32'd0);
        checkOutput("rst_b_ready", {31'd0, b_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Test 1: reset mid-burst drops the in-flight beat; afterwards a tie
        // goes to A.
        $display("[TB] test 1: reset mid-burst");
        applyStimulus(1'b0, 8'h55, 1'b0);
        checkOutput("t1_loaded_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("t1_loaded_data", {24'd0, out_data}, 32'h55);
        rst = 1'b1;
        #1;
        checkOutput("t1_rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("t1_rst_out_data", {24'd0, out_data}, 32'd0);
        checkOutput("t1_rst_a_ready", {31'd0, a_ready}, 32'd0);
        a_valid = 1'b0; a_last = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        pushExp(8'hA1, 1'b0);
        pushExp(8'hB1, 1'b1);
        fork
            begin applyStimulus(1'b0, 8'hA1, 1'b1); a_valid = 1'b0; end
            begin applyStimulus(1'b1, 8'hB1, 1'b1); b_valid = 1'b0; end
        join
        waitDrain("t1");

        // Test 2: A only, three beats on consecutive cycles, then IDLE.
        $display("[TB] test 2: A-only burst");
        pushExp(8'h11, 1'b0);
        pushExp(8'h22, 1'b0);
        pushExp(8'h33, 1'b0);
        fork
            begin
                applyStimulus(1'b0, 8'h11, 1'b0);
                applyStimulus(1'b0, 8'h22, 1'b0);
                applyStimulus(1'b0, 8'h33, 1'b1);
                a_valid = 1'b0;
            end
            expectStreak("t2", 3);
        join
        waitDrain("t2");
        @(negedge clk);
        checkOutput("t2_idle_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("t2_idle_a_ready", {31'd0, a_ready}, 32'd0);

        // Test 3: both sides always valid, no last; grants alternate 4A, 4B,
        // 4A, 4B with no bubble.
        $display("[TB] test 3: alternating bursts");
        resetDut();
        for (int i = 0; i < 4; i++) pushExp(8'hA0 + 8'(i), 1'b0);
        for (int i = 0; i < 4; i++) pushExp(8'hB0 + 8'(i), 1'b1);
        for (int i = 4; i < 8; i++) pushExp(8'hA0 + 8'(i), 1'b0);
        for (int i = 4; i < 8; i++) pushExp(8'hB0 + 8'(i), 1'b1);
        fork
            begin
                for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'hA0 + 8'(i), 1'b0);
                a_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'hB0 + 8'(i), 1'b0);
                b_valid = 1'b0;
            end
            expectStreak("t3", 16);
        join
        waitDrain("t3");

        // Test 4: a five-cycle downstream stall during a B burst.
        $display("[TB] test 4: output stall");
        pushExp(8'hC1, 1'b1);
        pushExp(8'hC2, 1'b1);
        pushExp(8'hC3, 1'b1);
        pushExp(8'hC4, 1'b1);
        fork
            begin
                applyStimulus(1'b1, 8'hC1, 1'b0);
                applyStimulus(1'b1, 8'hC2, 1'b0);
                applyStimulus(1'b1, 8'hC3, 1'b0);
                applyStimulus(1'b1, 8'hC4, 1'b1);
                b_valid = 1'b0;
            end
            begin
                int waitCycles;
                waitCycles = 0;
                @(negedge clk);
                while (!(out_valid && out_data == 8'hC1) && waitCycles < 50) begin
                    @(negedge clk);
                    waitCycles++;
                end
                checkOutput("t4_first_beat", {24'd0, out_data}, 32'hC1);
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    checkOutput("t4_hold_data", {24'd0, out_data}, 32'hC2);
                    checkOutput("t4_hold_valid", {31'd0, out_valid}, 32'd1);
                    checkOutput("t4_hold_b_ready", {31'd0, b_ready}, 32'd0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        waitDrain("t4");

        // Test 5: A goes quiet mid-burst; B must wait until A sends its last
        // beat.
        $display("[TB] test 5: grant held through gap");
        pushExp(8'hD1, 1'b0);
        pushExp(8'hD2, 1'b0);
        pushExp(8'hE1, 1'b1);
        fork
            begin
                applyStimulus(1'b0, 8'hD1, 1'b0);
                a_valid = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    checkOutput("t5_gap_b_ready", {31'd0, b_ready}, 32'd0);
                end
                @(posedge clk);
                #1;
                applyStimulus(1'b0, 8'hD2, 1'b1);
                a_valid = 1'b0;
            end
            begin
                applyStimulus(1'b1, 8'hE1, 1'b1);
                b_valid = 1'b0;
            end
        join
        waitDrain("t5");

`ifdef ARB_STATS_EN
        // Test 6: 20 A beats saturate a 4-bit counter at 0xF.
        $display("[TB] test 6: statistics saturation");
        resetDut();
        for (int i = 0; i < 20; i++) pushExp(8'(i), 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'(i), 1'b0);
        checkOutput("t6_cnt_a_mid", {28'd0, cnt_a}, 32'd10);
        for (int i = 10; i < 20; i++) applyStimulus(1'b0, 8'(i), 1'b0);
        a_valid = 1'b0;
        waitDrain("t6");
        checkOutput("t6_cnt_a_sat", {28'd0, cnt_a}, 32'hF);
        checkOutput("t6_cnt_b_zero", {28'd0, cnt_b}, 32'd0);
`endif

        repeat (3) @(negedge clk);
        checkOutput("final_queue_empty", expQ.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
